// File: rtl/conv_accum_pkg.sv
// Shared types and defaults for the ConvAccum partial-sum buffer.
package conv_accum_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int MEM_DEPTH_DEF  = 4096;
  // Width of row_in*col_in for 9-bit operands.
  localparam int DEPTH_W        = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAIN
  } state_e;

  function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [DEPTH_W-1:0] d,
                                                     input logic [DEPTH_W-1:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/accum_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module accum_dpram #(
  parameter int Width = 32,
  parameter int Depth = 4096,
  parameter int Aw    = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [Aw-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic [Aw-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // NOTE: the array and read register carry no reset so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_accum_buffer.sv
// Partial-sum buffer for ConvAccum: ACCUM read/write, CLEAR zero-fill, DRAIN stream.
// Build option: define ACCUM_RELU_EN to clamp drained negative sums to zero.
module conv_accum_buffer
  import conv_accum_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH_DEF,
  parameter int AddrWidth = ADDR_WIDTH_DEF,
  parameter int MemDepth  = MEM_DEPTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [8:0]           row_in,
  input  logic [8:0]           col_in,
  input  logic                 clear_start,
  input  logic                 drain_start,
  output logic                 busy,
  input  logic [AddrWidth-1:0] rd_addr_conv,
  output logic [DataWidth-1:0] rd_data_conv,
  input  logic [AddrWidth-1:0] wr_addr_conv,
  input  logic [DataWidth-1:0] wr_data_conv,
  input  logic                 wr_en_conv,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 err_addr
);

  localparam int RamAw = $clog2(MemDepth);
  typedef logic [DEPTH_W-1:0] depth_t;

  state_e state_q, state_d;
  depth_t depth_q, cnt_q;
  logic   err_q;

  logic   idle, start_any, req_ovf;
  depth_t req_depth, rd_addr_x, wr_addr_x;
  logic   rd_hit, wr_hit, wr_bad;

  assign idle      = (state_q == ST_IDLE);
  assign start_any = idle && (clear_start || drain_start);
  assign req_depth = depth_t'(row_in) * depth_t'(col_in);
  assign req_ovf   = req_depth > depth_t'(MemDepth);

  // Address 0 means "no access"; valid range is 1..depth.
  assign rd_addr_x = depth_t'(rd_addr_conv);
  assign wr_addr_x = depth_t'(wr_addr_conv);
  assign rd_hit    = idle && (rd_addr_x != '0) && (rd_addr_x <= depth_q);
  assign wr_hit    = idle && wr_en_conv && (wr_addr_x != '0) && (wr_addr_x <= depth_q);
  assign wr_bad    = idle && wr_en_conv && !wr_hit;

  // Drain skid buffer: two entries plus one read in flight in the RAM.
  logic [DataWidth-1:0] skid_data [2];
  logic [1:0]           skid_last;
  logic                 skid_head, skid_tail;
  logic [1:0]           skid_cnt, occ_after;
  logic                 inflight_q, inflight_last_q;
  logic                 pop, issue, clr_we;
  logic [DataWidth-1:0] head_word;

  assign pop       = out_valid && out_ready;
  assign occ_after = skid_cnt + {1'b0, inflight_q} - {1'b0, pop};
  assign issue     = (state_q == ST_DRAIN) && (cnt_q <= depth_q) && (occ_after <= 2'd1);
  assign clr_we    = (state_q == ST_CLEAR) && (cnt_q <= depth_q);
  assign skid_tail = skid_head ^ skid_cnt[0];
  assign head_word = skid_data[skid_head];

  // RAM port arbitration between ConvAccum and the sequencer.
  logic                 ram_we;
  logic [DataWidth-1:0] ram_wdata, ram_rdata;
  depth_t               waddr_sel, raddr_sel;
  logic [RamAw-1:0]     ram_waddr, ram_raddr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ram_we    = wr_hit;
    waddr_sel = wr_addr_x;
    ram_wdata = wr_data_conv;
    raddr_sel = rd_addr_x;
    if (state_q == ST_CLEAR) begin
      ram_we    = clr_we;
      waddr_sel = cnt_q;
      ram_wdata = '0;
    end
    if (state_q == ST_DRAIN) raddr_sel = cnt_q;
  end

  assign ram_waddr = RamAw'(waddr_sel - depth_t'(1));
  assign ram_raddr = RamAw'(raddr_sel - depth_t'(1));

  accum_dpram #(
    .Width(DataWidth),
    .Depth(MemDepth),
    .Aw   (RamAw)
  ) u_ram (
    .clk  (Clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start)      state_d = ST_CLEAR;
        else if (drain_start) state_d = ST_DRAIN;
      end
      ST_CLEAR: if (cnt_q >= depth_q) state_d = ST_IDLE;
      ST_DRAIN: if ((depth_q == '0) || (pop && out_last)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      depth_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_any) begin
        depth_q <= clamp_depth(req_depth, depth_t'(MemDepth));
        cnt_q   <= depth_t'(1);
      end else if (clr_we || issue) begin
        cnt_q <= cnt_q + depth_t'(1);
      end
      if ((start_any && req_ovf) || wr_bad) err_q <= 1'b1;
    end
  end

  // ACCUM read qualification and write-first forwarding, aligned with RAM latency.
  logic                 rd_ok_q, fwd_q;
  logic [DataWidth-1:0] fwd_data_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ok_q    <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_ok_q    <= rd_hit;
      fwd_q      <= wr_hit && (wr_addr_x == rd_addr_x);
      fwd_data_q <= wr_data_conv;
    end
  end

  assign rd_data_conv = !rd_ok_q ? '0 : (fwd_q ? fwd_data_q : ram_rdata);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 2; i++) skid_data[i] <= '0;
      skid_last       <= '0;
      skid_head       <= 1'b0;
      skid_cnt        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= (cnt_q == depth_q);
      if (inflight_q) begin
        skid_data[skid_tail] <= ram_rdata;
        skid_last[skid_tail] <= inflight_last_q;
      end
      if (pop) skid_head <= ~skid_head;
      skid_cnt <= skid_cnt + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign busy      = !idle;
  assign err_addr  = err_q;
  assign out_valid = (state_q == ST_DRAIN) && (skid_cnt != 2'd0);
  assign out_last  = out_valid && skid_last[skid_head];

`ifdef ACCUM_RELU_EN
  assign out_data = head_word[DataWidth-1] ? '0 : head_word;
`else
  assign out_data = head_word;
`endif

endmodule

// File: tb/tb_conv_accum_buffer.sv
// Directed scoreboard bench for conv_accum_buffer (ACCUM, CLEAR, DRAIN, errors, reset abort).
module tb_conv_accum_buffer;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic [8:0]  row_in = '0, col_in = '0;
  logic        clear_start = 1'b0, drain_start = 1'b0;
  logic        busy;
  logic [15:0] rd_addr_conv = '0, wr_addr_conv = '0;
  logic [31:0] rd_data_conv, wr_data_conv = '0;
  logic        wr_en_conv = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, out_last, err_addr;
  logic        out_ready = 1'b0;

  conv_accum_buffer dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .row_in      (row_in),
    .col_in      (col_in),
    .clear_start (clear_start),
    .drain_start (drain_start),
    .busy        (busy),
    .rd_addr_conv(rd_addr_conv),
    .rd_data_conv(rd_data_conv),
    .wr_addr_conv(wr_addr_conv),
    .wr_data_conv(wr_data_conv),
    .wr_en_conv  (wr_en_conv),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .err_addr    (err_addr)
  );

  always #5 Clk = ~Clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_mem [1:4096];
  int          model_depth = 0;
  logic [31:0] rd_exp [$];
  logic [31:0] out_exp [$];
  bit          rd_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef ACCUM_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (rd_pend) check("rd_data", rd_data_conv, rd_exp.pop_front());
    rd_pend      = 1'b0;
    wr_en_conv   = 1'b0;
    rd_addr_conv = '0;
    clear_start  = 1'b0;
    drain_start  = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en_conv   = 1'b1;
    wr_addr_conv = 16'(a);
    wr_data_conv = d;
    if (a >= 1 && a <= model_depth) model_mem[a] = d;
    tick();
  endtask

  task automatic rd(input int a);
    rd_addr_conv = 16'(a);
    rd_exp.push_back((a >= 1 && a <= model_depth) ? model_mem[a] : 32'd0);
    rd_pend = 1'b1;
    tick();
  endtask

  task automatic start_op(input int r, input int c, input bit clr, input bit drn);
    row_in      = 9'(r);
    col_in      = 9'(c);
    clear_start = clr;
    drain_start = drn;
    tick();
    model_depth = (r * c > 4096) ? 4096 : r * c;
    if (clr) for (int a = 1; a <= model_depth; a++) model_mem[a] = 32'd0;
  endtask

  task automatic wait_idle(output int cycles, output bit saw_valid);
    cycles    = 0;
    saw_valid = 1'b0;
    while (busy && cycles < 5000) begin
      cycles++;
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", rd_data_conv, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    rd_pend = 1'b0;
    rd_exp.delete();
    out_exp.delete();
    model_depth  = 0;
    wr_en_conv   = 1'b0;
    rd_addr_conv = '0;
    clear_start  = 1'b0;
    drain_start  = 1'b0;
    out_ready    = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
  endtask

  // Drain model_depth words; optionally stop after stop_after accepted words.
  task automatic run_drain(input bit toggle, input int stop_after);
    int          n = model_depth;
    int          got = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    logic [3:0]  pat = 4'b1001;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    out_exp.delete();
    for (int a = 1; a <= n; a++) out_exp.push_back(relu(model_mem[a]));
    out_ready   = 1'b1;
    drain_start = 1'b1;
    tick();
    while (got < stop_after && cyc < 1000) begin
      out_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        check("drain_data", out_data, out_exp.pop_front());
        check("drain_last", 32'(out_last), 32'(got == n - 1));
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      cyc++;
      tick();
    end
    check("drain_count", got, stop_after);
    if (stop_after == n) begin
      if (!toggle) check("drain_b2b", last_cyc - first_cyc, n - 1);
      check("drain_done_busy", 32'(busy), 32'd0);
      check("drain_done_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    bit saw;
    #2;
    do_reset();

    // Zero-fill a 6x6 layer and read every address back.
    start_op(6, 6, 1'b1, 1'b0);
    wait_idle(cyc, saw);
    check("clear_busy_cycles", cyc, 36);
    for (int a = 1; a <= 36; a++) rd(a);

    // Plain write/read, then same-cycle read and write forwarding.
    wr(5, 32'd1234);
    rd(5);
    wr_en_conv   = 1'b1;
    wr_addr_conv = 16'd7;
    wr_data_conv = -32'sd42;
    model_mem[7] = -32'sd42;
    rd(7);
    rd(7);
    check("err_after_accum", 32'(err_addr), 32'd0);

    // Ramp of signed sums drained at full rate, then with a stalling sink.
    for (int a = 1; a <= 36; a++) wr(a, 32'(a - 20));
    run_drain(1'b0, 36);
    run_drain(1'b1, 36);

    // Out-of-range writes are dropped and flag an error.
    wr(0, 32'd999);
    wr(37, 32'd999);
    check("err_bad_write", 32'(err_addr), 32'd1);
    rd(1);
    rd(36);

    // Oversized layer clamps to the physical depth.
    do_reset();
    start_op(100, 100, 1'b1, 1'b0);
    check("err_oversize", 32'(err_addr), 32'd1);
    wait_idle(cyc, saw);
    check("clamp_busy_cycles", cyc, 4096);
    wr(4096, 32'd77);
    rd(4096);
    wr(5, 32'd555);

    // Simultaneous starts: CLEAR only, the drain is dropped.
    start_op(6, 6, 1'b1, 1'b1);
    wait_idle(cyc, saw);
    check("dual_start_cycles", cyc, 36);
    check("dual_start_no_valid", 32'(saw), 32'd0);
    tick();
    check("dual_start_idle", 32'(busy), 32'd0);
    rd(5);

    // Reset in the middle of a drain, then a fresh drain from address 1.
    for (int a = 1; a <= 36; a++) wr(a, 32'(a - 20));
    run_drain(1'b0, 10);
    do_reset();
    start_op(6, 6, 1'b1, 1'b0);
    wait_idle(cyc, saw);
    for (int a = 1; a <= 36; a++) wr(a, 32'(3 * a));
    run_drain(1'b0, 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
